// File: rtl/sprite_overlay.sv
// Scans a 16-entry OAM each line into shadow slots, commits them atomically, and overlays them on a 1-cycle pixel path.
// Define SPRITE_COLLISION_EN to enable the sticky multi-sprite collision flag (otherwise tied low).
module sprite_overlay #(
  parameter int SLOTS    = 4,
  parameter int SPR_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic        oam_we,
  input  logic [3:0]  oam_addr,
  input  logic [33:0] oam_wdata,
  input  logic        in_valid,
  input  logic [8:0]  in_x,
  input  logic [15:0] in_color,
  output logic        out_valid,
  output logic [8:0]  out_x,
  output logic [15:0] out_color,
  output logic        eval_busy,
  output logic        sprite_overflow,
  output logic        sprite_collision,
  input  logic        collision_clr
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EVAL   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam int         CW     = $clog2(SLOTS + 1);
  localparam logic [8:0] SZ     = 9'(SPR_SIZE);

  logic [33:0]      oam_q [16];
  logic [33:0]      oam_d [16];
  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [8:0]       ly_q, ly_d;
  logic [SLOTS-1:0] sh_vld_q, sh_vld_d, act_vld_q, act_vld_d;
  logic [8:0]       sh_x_q [SLOTS];
  logic [8:0]       sh_x_d [SLOTS];
  logic [8:0]       act_x_q [SLOTS];
  logic [8:0]       act_x_d [SLOTS];
  logic [14:0]      sh_col_q [SLOTS];
  logic [14:0]      sh_col_d [SLOTS];
  logic [14:0]      act_col_q [SLOTS];
  logic [14:0]      act_col_d [SLOTS];
  logic [CW-1:0]    sh_cnt_q, sh_cnt_d;
  logic             sh_ovf_q, sh_ovf_d, ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [8:0]       out_x_q, out_x_d;
  logic [15:0]      out_color_q, out_color_d;

  logic [33:0]      ent;
  logic [8:0]       dy, dx;
  logic             hit, cov_any;
  logic [SLOTS-1:0] cov;
  logic [14:0]      cov_col;

  // Scan reads the registered OAM, so a same-cycle write is seen only on later scans.
  always_comb begin
    oam_d = oam_q;
    if (oam_we) oam_d[oam_addr] = oam_wdata;
  end

  always_comb begin
    ent = oam_q[idx_q];
    dy  = ly_q - ent[23:15];
    hit = ent[33] && (ly_q >= ent[23:15]) && (dy < SZ);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ly_d      = ly_q;
    sh_vld_d  = sh_vld_q;
    sh_x_d    = sh_x_q;
    sh_col_d  = sh_col_q;
    sh_cnt_d  = sh_cnt_q;
    sh_ovf_d  = sh_ovf_q;
    act_vld_d = act_vld_q;
    act_x_d   = act_x_q;
    act_col_d = act_col_q;
    ovf_d     = ovf_q;
    if (line_start) begin
      state_d  = EVAL;
      idx_d    = 4'd0;
      ly_d     = line_y;
      sh_vld_d = '0;
      sh_cnt_d = '0;
      sh_ovf_d = 1'b0;
    end else begin
      case (state_q)
        EVAL: begin
          if (hit) begin
            if (sh_cnt_q < CW'(SLOTS)) begin
              for (int i = 0; i < SLOTS; i++) begin
                if (sh_cnt_q == CW'(i)) begin
                  sh_vld_d[i] = 1'b1;
                  sh_x_d[i]   = ent[32:24];
                  sh_col_d[i] = ent[14:0];
                end
              end
              sh_cnt_d = sh_cnt_q + CW'(1);
            end else begin
              sh_ovf_d = 1'b1;
            end
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = COMMIT;
        end
        COMMIT: begin
          act_vld_d = sh_vld_q;
          act_x_d   = sh_x_q;
          act_col_d = sh_col_q;
          ovf_d     = sh_ovf_q;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Descending scan so the lowest-numbered covering slot wins.
  always_comb begin
    cov     = '0;
    cov_any = 1'b0;
    cov_col = '0;
    dx      = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      dx     = in_x - act_x_q[i];
      cov[i] = act_vld_q[i] && (in_x >= act_x_q[i]) && (dx < SZ);
      if (cov[i]) begin
        cov_any = 1'b1;
        cov_col = act_col_q[i];
      end
    end
    out_valid_d = in_valid;
    out_x_d     = in_valid ? in_x : out_x_q;
    out_color_d = !in_valid ? 16'h0000 : (cov_any ? {1'b0, cov_col} : in_color);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) oam_q[i] <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        sh_x_q[i]    <= '0;
        sh_col_q[i]  <= '0;
        act_x_q[i]   <= '0;
        act_col_q[i] <= '0;
      end
      state_q     <= IDLE;
      idx_q       <= '0;
      ly_q        <= '0;
      sh_vld_q    <= '0;
      act_vld_q   <= '0;
      sh_cnt_q    <= '0;
      sh_ovf_q    <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_color_q <= '0;
    end else begin
      oam_q       <= oam_d;
      sh_x_q      <= sh_x_d;
      sh_col_q    <= sh_col_d;
      act_x_q     <= act_x_d;
      act_col_q   <= act_col_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      ly_q        <= ly_d;
      sh_vld_q    <= sh_vld_d;
      act_vld_q   <= act_vld_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_ovf_q    <= sh_ovf_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_color_q <= out_color_d;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic coll_q, coll_d;
  always_comb coll_d = (in_valid && |(cov & (cov - SLOTS'(1)))) || (coll_q && !collision_clr);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end
  assign sprite_collision = coll_q;
`else
  logic unused_collision_clr;
  assign unused_collision_clr = collision_clr;
  assign sprite_collision     = 1'b0;
`endif

  assign out_valid       = out_valid_q;
  assign out_x           = out_x_q;
  assign out_color       = out_color_q;
  assign eval_busy       = (state_q != IDLE);
  assign sprite_overflow = ovf_q;
endmodule

// File: tb/tb_sprite_overlay.sv
// Directed bench for sprite_overlay: table-driven pixel vectors plus hand sequences for evaluation corner cases.
module tb_sprite_overlay;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [8:0]  line_y;
  logic        oam_we;
  logic [3:0]  oam_addr;
  logic [33:0] oam_wdata;
  logic        in_valid;
  logic [8:0]  in_x;
  logic [15:0] in_color;
  logic        out_valid;
  logic [8:0]  out_x;
  logic [15:0] out_color;
  logic        eval_busy;
  logic        sprite_overflow;
  logic        sprite_collision;
  logic        collision_clr;

  int checks   = 0;
  int failures = 0;

`ifdef SPRITE_COLLISION_EN
  localparam logic COLL = 1'b1;
`else
  localparam logic COLL = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [8:0]  x;
    logic [15:0] c;
    logic        ev;
    logic [8:0]  ex;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl[23];

  sprite_overlay #(.SLOTS(4), .SPR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
    .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .in_valid(in_valid), .in_x(in_x), .in_color(in_color),
    .out_valid(out_valid), .out_x(out_x), .out_color(out_color),
    .eval_busy(eval_busy), .sprite_overflow(sprite_overflow),
    .sprite_collision(sprite_collision), .collision_clr(collision_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic en, input logic [8:0] x, input logic [8:0] y,
                                     input logic [14:0] col);
    return {en, x, y, col};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [33:0] d);
    oam_we = 1'b1; oam_addr = a; oam_wdata = d;
    tick();
    oam_we = 1'b0;
  endtask

  task automatic run_eval(input logic [8:0] y);
    line_start = 1'b1; line_y = y;
    tick();
    line_start = 1'b0;
    repeat (17) tick();
  endtask

  task automatic pix(input string name, input logic [8:0] x, input logic [15:0] bg,
                     input logic [15:0] exp);
    in_valid = 1'b1; in_x = x; in_color = bg;
    tick();
    chk({name, "_vld"}, 32'(out_valid), 32'd1);
    chk({name, "_col"}, 32'(out_color), 32'(exp));
    in_valid = 1'b0;
  endtask

  initial begin
    int hold;
    logic busy16;
    rst_n = 1'b0; line_start = 1'b0; line_y = '0; oam_we = 1'b0; oam_addr = '0;
    oam_wdata = '0; in_valid = 1'b0; in_x = '0; in_color = '0; collision_clr = 1'b0;

    for (int i = 0; i <= 20; i++) begin
      tbl[i].v  = 1'b1;
      tbl[i].x  = 9'(i);
      tbl[i].c  = (i % 3 == 0) ? (16'h8000 | 16'(i)) : (16'h0100 + 16'(i));
      tbl[i].ev = 1'b1;
      tbl[i].ex = 9'(i);
      tbl[i].ec = (i >= 10 && i <= 17) ? 16'h7C00 : tbl[i].c;
    end
    tbl[21] = '{v: 1'b0, x: 9'd5,  c: 16'h1234, ev: 1'b0, ex: 9'd20, ec: 16'h0000};
    tbl[22] = '{v: 1'b1, x: 9'd17, c: 16'hFFFF, ev: 1'b1, ex: 9'd17, ec: 16'h7C00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_x", 32'(out_x), 0);
    chk("rst_out_color", 32'(out_color), 0);
    chk("rst_busy", 32'(eval_busy), 0);
    chk("rst_ovf", 32'(sprite_overflow), 0);
    chk("rst_coll", 32'(sprite_collision), 0);
    rst_n = 1'b1;
    tick();

    // Single sprite, table-driven stream
    wr(4'd0, mk(1'b1, 9'd10, 9'd20, 15'h7C00));
    pix("pre_eval", 9'd10, 16'h0123, 16'h0123);
    line_start = 1'b1; line_y = 9'd22;
    tick();
    line_start = 1'b0;
    chk("busy_eval", 32'(eval_busy), 1);
    repeat (16) tick();
    chk("busy_commit", 32'(eval_busy), 1);
    tick();
    chk("busy_idle", 32'(eval_busy), 0);
    for (int i = 0; i < 23; i++) begin
      in_valid = tbl[i].v; in_x = tbl[i].x; in_color = tbl[i].c;
      tick();
      chk($sformatf("vec%0d_vld", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_x", i), 32'(out_x), 32'(tbl[i].ex));
      chk($sformatf("vec%0d_col", i), 32'(out_color), 32'(tbl[i].ec));
    end
    in_valid = 1'b0;
    chk("single_coll", 32'(sprite_collision), 0);

    // Overflow: six hits on line 5
    for (int i = 0; i < 6; i++) wr(4'(i), mk(1'b1, 9'(20 * i), 9'(i), 15'(i + 1)));
    run_eval(9'd5);
    chk("ovf_set", 32'(sprite_overflow), 1);
    pix("ovf_e0", 9'd0, 16'h0200, 16'h0001);
    pix("ovf_e3", 9'd67, 16'h0200, 16'h0004);
    pix("ovf_e4", 9'd80, 16'h0201, 16'h0201);
    pix("ovf_e5", 9'd100, 16'h0202, 16'h0202);
    run_eval(9'd20);
    chk("ovf_clr", 32'(sprite_overflow), 0);
    pix("empty_line", 9'd0, 16'h0203, 16'h0203);

    // Priority and collision
    for (int i = 0; i < 6; i++) wr(4'(i), 34'd0);
    wr(4'd1, mk(1'b1, 9'd12, 9'd50, 15'h001F));
    wr(4'd2, mk(1'b1, 9'd12, 9'd50, 15'h7C00));
    run_eval(9'd52);
    pix("prio_11", 9'd11, 16'h0300, 16'h0300);
    chk("coll_before", 32'(sprite_collision), 0);
    pix("prio_12", 9'd12, 16'h0301, 16'h001F);
    chk("coll_set", 32'(sprite_collision), 32'(COLL));
    pix("prio_19", 9'd19, 16'h0302, 16'h001F);
    pix("prio_20", 9'd20, 16'h0303, 16'h0303);
    chk("coll_sticky", 32'(sprite_collision), 32'(COLL));
    collision_clr = 1'b1;
    tick();
    chk("coll_clr", 32'(sprite_collision), 0);
    pix("coll_setwin", 9'd13, 16'h0304, 16'h001F);
    chk("coll_setwin", 32'(sprite_collision), 32'(COLL));
    tick();
    collision_clr = 1'b0;
    chk("coll_clr2", 32'(sprite_collision), 0);

    // No wrap, vertical and horizontal
    wr(4'd1, 34'd0);
    wr(4'd2, 34'd0);
    wr(4'd0, mk(1'b1, 9'd508, 9'd300, 15'h03E0));
    run_eval(9'd4);
    pix("nowrap_l4", 9'd508, 16'h0400, 16'h0400);
    run_eval(9'd300);
    pix("l300_508", 9'd508, 16'h0401, 16'h03E0);
    pix("l300_511", 9'd511, 16'h0402, 16'h03E0);
    pix("l300_507", 9'd507, 16'h0403, 16'h0403);
    pix("l300_x0", 9'd0, 16'h0404, 16'h0404);
    pix("l300_x3", 9'd3, 16'h0405, 16'h0405);
    run_eval(9'd307);
    pix("l307", 9'd508, 16'h0406, 16'h03E0);
    run_eval(9'd308);
    pix("l308", 9'd508, 16'h0407, 16'h0407);
    run_eval(9'd299);
    pix("l299", 9'd508, 16'h0408, 16'h0408);

    // Restart mid-EVAL: old set holds until the restarted scan commits, shadow discarded
    wr(4'd1, mk(1'b1, 9'd100, 9'd400, 15'h1111));
    run_eval(9'd300);
    hold = 0; busy16 = 1'b0;
    in_valid = 1'b1; in_x = 9'd508; in_color = 16'h0555;
    line_start = 1'b1; line_y = 9'd400;
    tick();
    if (out_color == 16'h03E0) hold++;
    line_start = 1'b0;
    repeat (7) begin
      tick();
      if (out_color == 16'h03E0) hold++;
    end
    line_start = 1'b1; line_y = 9'd420;
    tick();
    if (out_color == 16'h03E0) hold++;
    line_start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (out_color == 16'h03E0) hold++;
      if (k == 16) busy16 = eval_busy;
    end
    chk("restart_hold", 32'(hold), 32'd26);
    chk("restart_busy16", 32'(busy16), 1);
    chk("restart_busy17", 32'(eval_busy), 0);
    tick();
    chk("restart_new", 32'(out_color), 32'h0555);
    in_valid = 1'b0;
    pix("restart_shadow", 9'd100, 16'h0777, 16'h0777);

    // Reset mid-EVAL
    run_eval(9'd300);
    pix("pre_rst", 9'd508, 16'h0600, 16'h03E0);
    line_start = 1'b1; line_y = 9'd300;
    tick();
    line_start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(eval_busy), 0);
    chk("mrst_vld", 32'(out_valid), 0);
    chk("mrst_col", 32'(out_color), 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    pix("post_rst", 9'd508, 16'h0601, 16'h0601);
    run_eval(9'd300);
    pix("post_rst_oam", 9'd508, 16'h0602, 16'h0602);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_overlay.md
SPRITE_OVERLAY -- requirements
Module: sprite_overlay

Interface
REQ-001 Parameter SLOTS, default 4: number of sprites composited per line (1..8).
REQ-002 Parameter SPR_SIZE, default 8: sprite width and height in pixels (power of two, 8 or 16).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 line_start  in  1  one-cycle pulse that starts sprite evaluation for line_y.
REQ-006 line_y  in  9  line number to evaluate, sampled with line_start.
REQ-007 oam_we  in  1  OAM write strobe.
REQ-008 oam_addr  in  4  OAM entry index, 16 entries.
REQ-009 oam_wdata  in  34  {enable[33], x[32:24], y[23:15], color[14:0]}.
REQ-010 in_valid  in  1  background pixel valid.
REQ-011 in_x  in  9  background pixel column.
REQ-012 in_color  in  16  background pixel; bit15 = transparent, [14:0] = RGB555.
REQ-013 out_valid, out_x, out_color  out  1/9/16  composited pixel, same format as input.
REQ-014 eval_busy  out  1  high while evaluation runs.
REQ-015 sprite_overflow  out  1  more than SLOTS sprites hit the last evaluated line.
REQ-016 sprite_collision  out  1  sticky collision flag (see Configuration).
REQ-017 collision_clr  in  1  clears sprite_collision.

Function
REQ-018 States: IDLE, EVAL, COMMIT; IDLE->EVAL on line_start; EVAL->COMMIT after 16 scan cycles; COMMIT->IDLE after one cycle.
REQ-019 EVAL reads one OAM entry per cycle, index 0..15 ascending; eval_busy high in EVAL and COMMIT.
REQ-020 Entry hits when enable=1, line_y >= y and (line_y - y) < SPR_SIZE, compared unsigned 9-bit; no vertical wrap.
REQ-021 Hits fill shadow slots in ascending OAM order, storing x, color, row; hits beyond SLOTS are dropped and set the overflow shadow bit.
REQ-022 COMMIT copies shadow slots and overflow bit into active slots and sprite_overflow in one cycle; pixels never see a partial slot set.
REQ-023 line_start during EVAL or COMMIT restarts EVAL at index 0 with cleared shadow; active slots unchanged.
REQ-024 OAM write completes on the edge of oam_we; an entry scanned in the same cycle uses the pre-write value.
REQ-025 Pixel path latency exactly 1 cycle: out_valid/out_x follow in_valid/in_x one cycle later, independent of FSM state.
REQ-026 Pixel covered by active slot when in_x >= slot.x and (in_x - slot.x) < SPR_SIZE, unsigned 9-bit; no horizontal wrap.
REQ-027 Covered pixel: out_color = {1'b0, color of lowest-numbered covering slot}; else out_color = in_color.
REQ-028 in_valid=0: out_valid=0, out_color=0, out_x holds last value.

Reset
REQ-029 rst_n low: state IDLE, all 16 OAM entries and all slots cleared (enable/valid 0).
REQ-030 rst_n low: out_valid, out_x, out_color, eval_busy, sprite_overflow, sprite_collision all 0.
REQ-031 Reset mid-EVAL abandons evaluation; after release the block composites nothing until a full evaluation completes.

Configuration
REQ-032 Macro SPRITE_COLLISION_EN defined: sprite_collision sets when >= 2 active slots cover a valid pixel, stays set until collision_clr; set wins over clear in the same cycle.
REQ-033 Macro SPRITE_COLLISION_EN undefined: no collision logic, sprite_collision tied 0, collision_clr ignored.

Verification
REQ-034 OAM0={1,x=10,y=20,0x7C00}, line_start line_y=22, stream x=0..20 -> x=10..17 out 0x7C00 one cycle later, others = input.
REQ-035 Six enabled entries all covering line 5, line_start -> entries 0..3 in slots, sprite_overflow=1 after COMMIT, entries 4/5 invisible.
REQ-036 OAM1 x=12 blue, OAM2 x=12 red both on line -> pixels 12..19 blue; with SPRITE_COLLISION_EN, collision=1 until collision_clr.
REQ-037 Sprite y=300 line_y=4 and x=508 stream x=0..511 -> no wrap: line 4 no hit; line 300 only x=508..511 covered.
REQ-038 line_start at EVAL cycle 7, then streaming during EVAL -> pixels use previous slot set; new set only after the restarted EVAL commits 18 cycles later.
